// File: rtl/spi_frame_ctrl.sv
// -----------------------------------------------------------------------------
// spi_frame_ctrl
//
// Frame-level controller behind a byte-level SPI receiver. Each chip-select
// window is one register-access frame. The first byte is a command byte:
// bit 7 selects write (1) or read (0), and the low ADDR_W bits give the start
// address. The remaining bytes are either write data or dummy bytes that clock
// out read data. The address auto-increments and wraps.
//
// Ports:
//   clk, reset_n           system clock, asynchronous active-low reset
//   cs_n                   raw SPI chip-select (active low), 2-flop synchronized
//   rx_data, rx_valid      received byte and its one-cycle strobe
//   reg_wr_en, reg_rd_en   one-cycle register bus strobes (never both high)
//   reg_addr, reg_wdata    register bus address / write data
//   reg_rdata              register read data, valid 1 cycle after reg_rd_en
//   tx_data, tx_load       byte for the SPI transmitter and its load strobe
//   frame_done, frame_err  end-of-frame pulse; err = frame had no command byte
//   frame_bytes            byte count of last frame (saturating), held
//   busy                   high while a frame is being decoded
// -----------------------------------------------------------------------------
module spi_frame_ctrl #(
  parameter int ADDR_W = 7,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cs_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              reg_wr_en,
  output logic              reg_rd_en,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  input  logic [7:0]        reg_rdata,
  output logic [7:0]        tx_data,
  output logic              tx_load,
  output logic              frame_done,
  output logic              frame_err,
  output logic [CNT_W-1:0]  frame_bytes,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_WR   = 2'd2,
    ST_RD   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t            state_r;
  logic              cs_meta_r;
  logic              cs_sync_r;
  logic              cs_active_s;
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W-1:0] addr_inc_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_next_s;
  logic              rd_pend_r;

  // Address increment wraps naturally at 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] addr_next(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(1);
  endfunction

  assign cs_active_s = ~cs_sync_r;
  assign addr_inc_s  = addr_next(addr_r);

  // Two-flop synchronizer for the raw chip-select; idles high (inactive).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cs_meta_r <= 1'b1;
      cs_sync_r <= 1'b1;
    end else begin
      cs_meta_r <= cs_n;
      cs_sync_r <= cs_meta_r;
    end
  end

  // Byte counter value after this cycle's byte (if any) has been counted.
  // Used both to update the counter and to report a frame that closes in the
  // same cycle as its last byte.
  always_comb begin
    cnt_next_s = cnt_r;
    case (state_r)
      ST_IDLE: cnt_next_s = {CNT_W{1'b0}};
      ST_CMD: begin
        if (rx_valid) cnt_next_s = CNT_W'(1);
        else          cnt_next_s = cnt_r;
      end
      ST_WR, ST_RD: begin
        if (rx_valid && (cnt_r != CNT_MAX)) cnt_next_s = cnt_r + CNT_W'(1);
        else                                cnt_next_s = cnt_r;
      end
      default: cnt_next_s = {CNT_W{1'b0}};
    endcase
  end

  // Frame FSM: command decode, write/read sequencing, frame close.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      addr_r      <= {ADDR_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      reg_wr_en   <= 1'b0;
      reg_rd_en   <= 1'b0;
      reg_addr    <= {ADDR_W{1'b0}};
      reg_wdata   <= 8'h00;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      frame_bytes <= {CNT_W{1'b0}};
      busy        <= 1'b0;
    end else begin
      reg_wr_en  <= 1'b0;
      reg_rd_en  <= 1'b0;
      frame_done <= 1'b0;
      cnt_r      <= cnt_next_s;

      case (state_r)
        ST_IDLE: begin
          if (cs_active_s) begin
            state_r <= ST_CMD;
            busy    <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
          end
        end
        ST_CMD: begin
          if (rx_valid) begin
            addr_r <= rx_data[ADDR_W-1:0];
            if (rx_data[7]) begin
              state_r <= ST_WR;
            end else begin
              // First read targets the command address itself.
              state_r   <= ST_RD;
              reg_rd_en <= 1'b1;
              reg_addr  <= rx_data[ADDR_W-1:0];
            end
          end
        end
        ST_WR: begin
          if (rx_valid) begin
            reg_wr_en <= 1'b1;
            reg_addr  <= addr_r;
            reg_wdata <= rx_data;
            addr_r    <= addr_inc_s;
          end
        end
        ST_RD: begin
          // Dummy byte advances to the next address and fetches it.
          if (rx_valid) begin
            addr_r    <= addr_inc_s;
            reg_rd_en <= 1'b1;
            reg_addr  <= addr_inc_s;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase

      // Frame close overrides the next state but keeps the byte processing
      // above, so a byte arriving with the cs release is still handled.
      if ((state_r != ST_IDLE) && !cs_active_s) begin
        state_r     <= ST_IDLE;
        busy        <= 1'b0;
        frame_done  <= 1'b1;
        frame_bytes <= cnt_next_s;
        frame_err   <= (state_r == ST_CMD) && !rx_valid;
      end
    end
  end

  // Read return pipeline: rdata sampled the cycle after reg_rd_en, presented
  // to the transmitter one cycle later. Runs independently of the frame FSM
  // so an in-flight read completes after the frame has closed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pend_r <= 1'b0;
      tx_load   <= 1'b0;
      tx_data   <= 8'h00;
    end else begin
      rd_pend_r <= reg_rd_en;
      tx_load   <= rd_pend_r;
      if (rd_pend_r) tx_data <= reg_rdata;
      else           tx_data <= tx_data;
    end
  end

endmodule

// File: tb/tb_spi_frame_ctrl.sv
module tb_spi_frame_ctrl;

  localparam int ADDR_W = 7;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              cs_n = 1'b1;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic              reg_wr_en;
  logic              reg_rd_en;
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        reg_wdata;
  logic [7:0]        reg_rdata = 8'h00;
  logic [7:0]        tx_data;
  logic              tx_load;
  logic              frame_done;
  logic              frame_err;
  logic [CNT_W-1:0]  frame_bytes;
  logic              busy;

  spi_frame_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .cs_n(cs_n), .rx_data(rx_data),
    .rx_valid(rx_valid), .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
    .tx_data(tx_data), .tx_load(tx_load), .frame_done(frame_done),
    .frame_err(frame_err), .frame_bytes(frame_bytes), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Register file model: contents are addr + 0x40, returned one cycle after
  // the read strobe.
  function automatic logic [7:0] rd_val(input logic [6:0] a);
    return {1'b0, a} + 8'h40;
  endfunction

  always @(posedge clk) reg_rdata <= reg_rd_en ? rd_val(reg_addr) : 8'h00;

  // Observed events
  int          rx_cyc_q[$];
  logic [14:0] wr_q[$];
  int          wr_cyc_q[$];
  logic [6:0]  rd_q[$];
  int          rd_cyc_q[$];
  logic [7:0]  tx_q[$];
  int          tx_cyc_q[$];
  logic [8:0]  fd_q[$];
  int          both_cnt = 0;
  int          busy_bad = 0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (rx_valid) rx_cyc_q.push_back(cyc);
      if (reg_wr_en) begin
        wr_q.push_back({reg_addr, reg_wdata});
        wr_cyc_q.push_back(cyc);
      end
      if (reg_rd_en) begin
        rd_q.push_back(reg_addr);
        rd_cyc_q.push_back(cyc);
      end
      if (tx_load) begin
        tx_q.push_back(tx_data);
        tx_cyc_q.push_back(cyc);
      end
      if (reg_wr_en && reg_rd_en) both_cnt++;
      if (frame_done) begin
        fd_q.push_back({frame_err, frame_bytes});
        if (busy) busy_bad++;
      end
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_caps();
    rx_cyc_q.delete(); wr_q.delete(); wr_cyc_q.delete();
    rd_q.delete(); rd_cyc_q.delete(); tx_q.delete(); tx_cyc_q.delete();
    fd_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr_en"}, reg_wr_en, 0);
    check({tag, "_rd_en"}, reg_rd_en, 0);
    check({tag, "_addr"}, reg_addr, 0);
    check({tag, "_wdata"}, reg_wdata, 0);
    check({tag, "_tx_data"}, tx_data, 0);
    check({tag, "_tx_load"}, tx_load, 0);
    check({tag, "_done"}, frame_done, 0);
    check({tag, "_err"}, frame_err, 0);
    check({tag, "_bytes"}, frame_bytes, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  // Frame stimulus: bytes in fb, random gaps up to gap_max, cs held low for
  // 'hold' extra cycles. race=1 delivers the last byte exactly in the cycle
  // the synchronized chip-select goes inactive.
  logic [7:0] fb[$];
  int         gap_max = 1;

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic drive_frame(input bit race, input int hold);
    int last;
    last = (race && fb.size() > 0) ? fb.size() - 1 : fb.size();
    cs_n = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check("busy_in_frame", busy, 1);
    for (int i = 0; i < last; i++) send_byte(fb[i], $urandom_range(0, gap_max));
    repeat (hold) begin @(posedge clk); #1; end
    cs_n = 1'b1;
    if (last != fb.size()) begin
      @(posedge clk); #1;
      @(posedge clk); #1;
      send_byte(fb[last], 0);
    end
    repeat (8) begin @(posedge clk); #1; end
  endtask

  // Reference: what a frame made of fb must produce, from the frame rules.
  task automatic check_model(input string tag);
    int         n;
    logic [6:0] a;
    logic       exp_err;
    logic [7:0] exp_b;
    n       = fb.size();
    exp_err = (n == 0);
    exp_b   = (n > 255) ? 8'hFF : 8'(n);
    check({tag, "_rx_cnt"}, rx_cyc_q.size(), n);
    check({tag, "_done_cnt"}, fd_q.size(), 1);
    if (fd_q.size() > 0) check({tag, "_err_bytes"}, fd_q[0], {exp_err, exp_b});
    if (n == 0) begin
      check({tag, "_wr_cnt"}, wr_q.size(), 0);
      check({tag, "_rd_cnt"}, rd_q.size(), 0);
      check({tag, "_tx_cnt"}, tx_q.size(), 0);
    end else begin
      a = fb[0][6:0];
      if (fb[0][7]) begin
        check({tag, "_wr_cnt"}, wr_q.size(), n - 1);
        check({tag, "_rd_cnt"}, rd_q.size(), 0);
        for (int i = 1; i < n; i++) begin
          if (i - 1 < wr_q.size() && i < rx_cyc_q.size()) begin
            check({tag, "_wr"}, wr_q[i-1], {a + 7'(i - 1), fb[i]});
            check({tag, "_wr_lat"}, wr_cyc_q[i-1], rx_cyc_q[i] + 1);
          end
        end
      end else begin
        check({tag, "_wr_cnt"}, wr_q.size(), 0);
        check({tag, "_rd_cnt"}, rd_q.size(), n);
        check({tag, "_tx_cnt"}, tx_q.size(), n);
        for (int i = 0; i < n; i++) begin
          if (i < rd_q.size() && i < tx_q.size() && i < rx_cyc_q.size()) begin
            check({tag, "_rd_addr"}, rd_q[i], a + 7'(i));
            check({tag, "_rd_lat"}, rd_cyc_q[i], rx_cyc_q[i] + 1);
            check({tag, "_tx"}, tx_q[i], rd_val(a + 7'(i)));
            check({tag, "_tx_lat"}, tx_cyc_q[i], rd_cyc_q[i] + 2);
          end
        end
      end
    end
  endtask

  typedef struct {
    int          n;
    logic [31:0] b;
    int          hold;
    logic        exp_err;
    logic [7:0]  exp_bytes;
    int          exp_nwr;
    int          exp_nrd;
    logic [6:0]  exp_last_addr;
    logic [7:0]  exp_last_val;
  } vec_t;

  vec_t tbl[4];

  initial begin
    tbl[0] = '{3, 32'h85AABB00, 0,  1'b0, 8'd3, 2, 0, 7'h06, 8'hBB};
    tbl[1] = '{3, 32'h10000000, 0,  1'b0, 8'd3, 0, 3, 7'h12, 8'h52};
    tbl[2] = '{4, 32'hFF010203, 0,  1'b0, 8'd4, 3, 0, 7'h01, 8'h03};
    tbl[3] = '{0, 32'h00000000, 16, 1'b1, 8'd0, 0, 0, 7'h00, 8'h00};

    // Reset state
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end

    // Byte while idle is ignored
    clear_caps();
    send_byte(8'h85, 3);
    check("idle_rx_wr", wr_q.size(), 0);
    check("idle_rx_rd", rd_q.size(), 0);
    check("idle_rx_busy", busy, 0);

    // Directed table
    gap_max = 1;
    for (int k = 0; k < 4; k++) begin
      clear_caps();
      fb.delete();
      for (int i = 0; i < tbl[k].n; i++) fb.push_back(tbl[k].b[31-8*i -: 8]);
      drive_frame(1'b0, tbl[k].hold);
      check("tbl_nwr", wr_q.size(), tbl[k].exp_nwr);
      check("tbl_nrd", rd_q.size(), tbl[k].exp_nrd);
      check("tbl_ndone", fd_q.size(), 1);
      if (fd_q.size() > 0) begin
        check("tbl_err", fd_q[0][8], tbl[k].exp_err);
        check("tbl_bytes", fd_q[0][7:0], tbl[k].exp_bytes);
      end
      if (tbl[k].exp_nwr > 0 && wr_q.size() > 0)
        check("tbl_last_wr", wr_q[wr_q.size()-1], {tbl[k].exp_last_addr, tbl[k].exp_last_val});
      if (tbl[k].exp_nrd > 0 && rd_q.size() > 0 && tx_q.size() > 0) begin
        check("tbl_last_rd", rd_q[rd_q.size()-1], tbl[k].exp_last_addr);
        check("tbl_last_tx", tx_q[tx_q.size()-1], tbl[k].exp_last_val);
      end
      check_model("tbl");
    end

    // Edge race: final byte arrives with the chip-select release
    clear_caps();
    fb = '{8'h82, 8'h33};
    drive_frame(1'b1, 0);
    check("race_wr_cnt", wr_q.size(), 1);
    if (wr_q.size() > 0) check("race_wr", wr_q[0], {7'h02, 8'h33});
    check("race_done_cnt", fd_q.size(), 1);
    if (fd_q.size() > 0) check("race_bytes", fd_q[0], {1'b0, 8'd2});

    // Reset in the middle of a write frame
    clear_caps();
    cs_n = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    send_byte(8'h83, 1);
    send_byte(8'hC3, 1);
    check("midrst_pre_wr", wr_q.size(), 1);
    clear_caps();
    reset_n = 1'b0;
    #1;
    check_all_zero("midrst");
    cs_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    reset_n = 1'b1;
    repeat (6) begin @(posedge clk); #1; end
    check("midrst_no_done", fd_q.size(), 0);
    clear_caps();
    fb = '{8'h81, 8'h5A};
    drive_frame(1'b0, 0);
    if (wr_q.size() > 0) check("post_rst_wr", wr_q[0], {7'h01, 8'h5A});
    check_model("post_rst");

    // Randomized frames against the reference
    gap_max = 2;
    for (int f = 0; f < 30; f++) begin
      int n;
      clear_caps();
      fb.delete();
      n = $urandom_range(0, 5);
      for (int i = 0; i < n; i++) fb.push_back(8'($urandom));
      drive_frame(n > 0 && $urandom_range(0, 3) == 0, $urandom_range(0, 2));
      check_model("rand");
    end

    // Byte counter saturation
    gap_max = 0;
    clear_caps();
    fb.delete();
    fb.push_back(8'h80);
    for (int i = 0; i < 299; i++) fb.push_back(8'($urandom));
    drive_frame(1'b0, 0);
    if (fd_q.size() > 0) check("sat_bytes", fd_q[0][7:0], 8'hFF);
    check_model("sat");

    check("strobe_excl", both_cnt, 0);
    check("busy_at_done", busy_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
